// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory.
// Handshake: i_req/d_req are levels held until the matching one-cycle x_valid; mem_req is held until a one-cycle mem_ack.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_i;
  logic        stall_d;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_rdata, i_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
           stall_i, stall_d
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_rdata, i_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata,
           stall_i, stall_d
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single-port memory: data priority with an
// anti-starvation streak limit for fetch, plus a per-access timeout with a sticky error.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_arbiter_if.master        bus,
  output logic                 err,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam int             WW    = $clog2(TIMEOUT + 1);
  localparam logic [2:0]     LIMIT = 3'(STARVE_LIMIT);
  localparam logic [WW-1:0]  TMAX  = WW'(TIMEOUT);

  state_t        state, state_nxt;
  logic [2:0]    streak;
  logic [WW-1:0] wait_cnt;
  logic          busy, timeout, done, grant_d, grant_i;

  assign busy    = (state != IDLE);
  assign timeout = busy && (wait_cnt == TMAX);
  // An ack landing in the timeout cycle is a normal completion.
  assign done    = busy && (bus.mem_ack || timeout);
  assign grant_d = (state == IDLE) && bus.d_req && (!bus.i_req || (streak < LIMIT));
  assign grant_i = (state == IDLE) && bus.i_req && !grant_d;

  assign dbg_state   = state;
  assign bus.stall_i = bus.i_req & ~bus.i_valid;
  assign bus.stall_d = bus.d_req & ~bus.d_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = BUSY_D;
        else if (grant_i) state_nxt = BUSY_I;
      end
      BUSY_I, BUSY_D: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.i_valid = 1'b0;
    bus.i_rdata = '0;
    bus.d_valid = 1'b0;
    bus.d_rdata = '0;
    if (state == BUSY_I && done) begin
      bus.i_valid = 1'b1;
      bus.i_rdata = bus.mem_ack ? bus.mem_rdata : '0;
    end
    if (state == BUSY_D && done) begin
      bus.d_valid = 1'b1;
      bus.d_rdata = bus.mem_ack ? bus.mem_rdata : '0;
    end
  end

  // Memory-side registers, streak and wait counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      streak        <= '0;
      wait_cnt      <= '0;
      err           <= 1'b0;
    end else begin
      if (grant_d) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= bus.d_we;
        bus.mem_addr  <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
      end else if (grant_i) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= 1'b0;
        bus.mem_addr  <= bus.i_addr;
        bus.mem_wdata <= '0;
      end else if (done) begin
        bus.mem_req <= 1'b0;
        bus.mem_we  <= 1'b0;
      end

      if (grant_d) begin
        if (!bus.i_req)           streak <= '0;
        else if (streak != LIMIT) streak <= streak + 3'd1;
      end else if (grant_i) begin
        streak <= '0;
      end

      if (grant_d || grant_i)                  wait_cnt <= '0;
      else if (busy && !bus.mem_ack && !timeout) wait_cnt <= wait_cnt + WW'(1);

      if (timeout && !bus.mem_ack) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, collision, starvation, timeout, reset abort, stray ack.
module tb_mem_arbiter;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       err;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #1 rst = 1'b0;
    #1;
    checks++; if ({bus.mem_req, bus.mem_we} !== 2'b00) begin errors++; $display("FAIL reset_req_we: got %b expected 00", {bus.mem_req, bus.mem_we}); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.mem_wdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    step(); step();
    rst = 1'b1;
    #1;
    checks++; if ({bus.i_valid, bus.d_valid} !== 2'b00) begin errors++; $display("FAIL reset_valids: got %b expected 00", {bus.i_valid, bus.d_valid}); end
  endtask

  task automatic test_fetch();
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    #1;
    checks++; if (bus.stall_i !== 1'b1) begin errors++; $display("FAIL fetch_stall_idle: got %b expected 1", bus.stall_i); end
    step();
    checks++; if ({bus.mem_req, bus.mem_we} !== 2'b10) begin errors++; $display("FAIL fetch_req_we: got %b expected 10", {bus.mem_req, bus.mem_we}); end
    checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL fetch_addr: got %h expected 100", bus.mem_addr); end
    for (int k = 0; k < 3; k++) begin
      checks++; if ({bus.i_valid, bus.stall_i} !== 2'b01) begin errors++; $display("FAIL fetch_wait: got %b expected 01 (cycle %0d)", {bus.i_valid, bus.stall_i}, k); end
      step();
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE0001;
    #1;
    checks++; if ({bus.i_valid, bus.d_valid, bus.stall_i} !== 3'b100) begin errors++; $display("FAIL fetch_valid: got %b expected 100", {bus.i_valid, bus.d_valid, bus.stall_i}); end
    checks++; if (bus.i_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL fetch_rdata: got %h expected cafe0001", bus.i_rdata); end
    step();
    bus.mem_ack = 1'b0; bus.i_req = 1'b0;
    #1;
    checks++; if ({bus.mem_req, bus.i_valid, dbg_state} !== {2'b00, S_IDLE}) begin errors++; $display("FAIL fetch_done: got %b expected 0000", {bus.mem_req, bus.i_valid, dbg_state}); end
    checks++; if (bus.i_rdata !== 32'h0) begin errors++; $display("FAIL fetch_rdata_zero: got %h expected 0", bus.i_rdata); end
  endtask

  task automatic test_collision();
    bus.i_req = 1'b1; bus.i_addr = 32'h300;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEADBEEF;
    step();
    checks++; if (dbg_state !== S_BUSY_D) begin errors++; $display("FAIL coll_first_state: got %0d expected 2", dbg_state); end
    checks++; if ({bus.mem_req, bus.mem_we} !== 2'b11) begin errors++; $display("FAIL coll_req_we: got %b expected 11", {bus.mem_req, bus.mem_we}); end
    checks++; if ({bus.mem_addr, bus.mem_wdata} !== {32'h2000, 32'hDEADBEEF}) begin errors++; $display("FAIL coll_addr_data: got %h expected 00002000deadbeef", {bus.mem_addr, bus.mem_wdata}); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11112222;
    #1;
    checks++; if ({bus.d_valid, bus.i_valid} !== 2'b10) begin errors++; $display("FAIL coll_d_first: got %b expected 10", {bus.d_valid, bus.i_valid}); end
    checks++; if (bus.d_rdata !== 32'h11112222) begin errors++; $display("FAIL coll_d_rdata: got %h expected 11112222", bus.d_rdata); end
    step();
    bus.mem_ack = 1'b0; bus.d_req = 1'b0;
    #1;
    checks++; if ({bus.mem_req, bus.mem_we, dbg_state} !== {2'b00, S_IDLE}) begin errors++; $display("FAIL coll_release: got %b expected 0000", {bus.mem_req, bus.mem_we, dbg_state}); end
    step();
    checks++; if ({dbg_state, bus.mem_we} !== {S_BUSY_I, 1'b0}) begin errors++; $display("FAIL coll_fetch_grant: got %b expected 010", {dbg_state, bus.mem_we}); end
    checks++; if ({bus.mem_addr, bus.mem_wdata} !== {32'h300, 32'h0}) begin errors++; $display("FAIL coll_fetch_addr: got %h expected 0000030000000000", {bus.mem_addr, bus.mem_wdata}); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
    #1;
    checks++; if ({bus.i_valid, bus.d_valid, bus.i_rdata} !== {2'b10, 32'h12345678}) begin errors++; $display("FAIL coll_fetch_valid: got %h expected 2_12345678", {bus.i_valid, bus.d_valid, bus.i_rdata}); end
    step();
    bus.mem_ack = 1'b0; bus.i_req = 1'b0;
  endtask

  task automatic test_starvation();
    logic fetch;
    bus.i_req = 1'b1; bus.i_addr = 32'h500;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4000; bus.d_wdata = 32'h0;
    for (int g = 0; g < 10; g++) begin
      fetch = ((g % 5) == 4);
      step();
      checks++; if (dbg_state !== (fetch ? S_BUSY_I : S_BUSY_D)) begin errors++; $display("FAIL starve_grant: grant %0d got state %0d expected %0d", g, dbg_state, fetch ? S_BUSY_I : S_BUSY_D); end
      checks++; if (bus.mem_addr !== (fetch ? 32'h500 : 32'h4000)) begin errors++; $display("FAIL starve_addr: grant %0d got %h expected %h", g, bus.mem_addr, fetch ? 32'h500 : 32'h4000); end
      step();
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hC0000000 + g;
      #1;
      checks++; if ({bus.i_valid, bus.d_valid} !== (fetch ? 2'b10 : 2'b01)) begin errors++; $display("FAIL starve_valid: grant %0d got %b expected %b", g, {bus.i_valid, bus.d_valid}, fetch ? 2'b10 : 2'b01); end
      checks++; if ((fetch ? bus.i_rdata : bus.d_rdata) !== 32'hC0000000 + g) begin errors++; $display("FAIL starve_rdata: grant %0d got %h expected %h", g, fetch ? bus.i_rdata : bus.d_rdata, 32'hC0000000 + g); end
      step();
      bus.mem_ack = 1'b0;
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
  endtask

  task automatic test_timeout();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h6000;
    bus.mem_rdata = 32'hFFFFFFFF;
    step();
    checks++; if ({dbg_state, bus.mem_req} !== {S_BUSY_D, 1'b1}) begin errors++; $display("FAIL tmo_grant: got %b expected 101", {dbg_state, bus.mem_req}); end
    for (int k = 0; k < 16; k++) begin
      checks++; if ({bus.d_valid, bus.stall_d, bus.mem_addr} !== {2'b01, 32'h6000}) begin errors++; $display("FAIL tmo_wait: cycle %0d got %h expected 1_00006000", k, {bus.d_valid, bus.stall_d, bus.mem_addr}); end
      step();
    end
    checks++; if ({bus.d_valid, bus.d_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL tmo_valid: got %h expected 1_00000000", {bus.d_valid, bus.d_rdata}); end
    step();
    bus.d_req = 1'b0;
    #1;
    checks++; if ({err, bus.mem_req, dbg_state} !== {2'b10, S_IDLE}) begin errors++; $display("FAIL tmo_after: got %b expected 1000", {err, bus.mem_req, dbg_state}); end
    step(); step(); step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_reset_mid_access();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h7000; bus.d_wdata = 32'h55;
    bus.i_req = 1'b1; bus.i_addr = 32'h800;
    step();
    checks++; if ({dbg_state, bus.mem_req} !== {S_BUSY_D, 1'b1}) begin errors++; $display("FAIL rmid_grant: got %b expected 101", {dbg_state, bus.mem_req}); end
    rst = 1'b0;
    #1;
    checks++; if ({bus.mem_req, bus.mem_we, bus.d_valid, err, dbg_state} !== {4'b0000, S_IDLE}) begin errors++; $display("FAIL rmid_abort: got %b expected 000000", {bus.mem_req, bus.mem_we, bus.d_valid, err, dbg_state}); end
    step();
    bus.d_req = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (bus.d_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_valid: got %b expected 0", bus.d_valid); end
    step();
    checks++; if ({dbg_state, bus.mem_addr} !== {S_BUSY_I, 32'h800}) begin errors++; $display("FAIL rmid_fetch: got %h expected 1_00000800", {dbg_state, bus.mem_addr}); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BADF00D;
    #1;
    checks++; if ({bus.i_valid, bus.i_rdata} !== {1'b1, 32'h0BADF00D}) begin errors++; $display("FAIL rmid_fetch_valid: got %h expected 1_0badf00d", {bus.i_valid, bus.i_rdata}); end
    step();
    bus.mem_ack = 1'b0; bus.i_req = 1'b0;
  endtask

  task automatic test_ack_at_timeout();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h9000;
    step();
    for (int k = 0; k < 16; k++) step();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hA5A5A5A5;
    #1;
    checks++; if ({bus.d_valid, bus.d_rdata} !== {1'b1, 32'hA5A5A5A5}) begin errors++; $display("FAIL ackto_valid: got %h expected 1_a5a5a5a5", {bus.d_valid, bus.d_rdata}); end
    step();
    bus.mem_ack = 1'b0; bus.d_req = 1'b0;
    #1;
    checks++; if ({err, dbg_state} !== {1'b0, S_IDLE}) begin errors++; $display("FAIL ackto_err: got %b expected 000", {err, dbg_state}); end
  endtask

  task automatic test_stray_ack();
    idle_inputs();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h77777777;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if ({bus.i_valid, bus.d_valid, bus.i_rdata, bus.d_rdata} !== 66'h0) begin errors++; $display("FAIL stray_valid: cycle %0d got %h expected 0", k, {bus.i_valid, bus.d_valid, bus.i_rdata, bus.d_rdata}); end
      step();
      checks++; if ({dbg_state, bus.mem_req} !== {S_IDLE, 1'b0}) begin errors++; $display("FAIL stray_state: cycle %0d got %b expected 000", k, {dbg_state, bus.mem_req}); end
    end
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_collision();
    test_starvation();
    test_timeout();
    test_reset_mid_access();
    test_ack_at_timeout();
    test_stray_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
